maze_state: RTL
===============

MAZE_STATE -- requirements
Module: maze_state

Interface
REQ-001 SHALL have parameter MAZE_W, default 28, meaning maze width in tiles.
REQ-002 SHALL have parameter MAZE_H, default 36, meaning maze height in tiles.
REQ-003 SHALL have parameter PELLET_TOTAL, default 244, meaning pellets in a fresh maze (normal plus power).
REQ-004 SHALL have parameter POWER_FRAMES, default 360, meaning the power-mode duration in frames.
REQ-005 SHALL have ports: clk  in  1  system clock (at least 64 cycles per frame).
REQ-006 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports: frame_tick  in  1  one-cycle pulse at the start of each 60 Hz frame.
REQ-008 SHALL have ports: pause  in  1  sampled at frame_tick; suppresses eating and holds the power timer.
REQ-009 SHALL have ports: level_restart  in  1  one-cycle pulse that refills all pellets.
REQ-010 SHALL have ports: pacman_tiles, blinky_tiles, pinky_tiles, inky_tiles, clyde_tiles  in  12 each  center tile query, {x[11:6], y[5:0]}.
REQ-011 SHALL have ports: pacman_tile_info, blinky_tile_info, pinky_tile_info, inky_tile_info, clyde_tile_info  out  8 each  neighbor info, [7:6] up, [5:4] left, [3:2] down, [1:0] right.
REQ-012 SHALL have ports: pacman_pellet  out  1  Pac-Man ate a pellet this frame.
REQ-013 SHALL have ports: power_pellet  out  1  power mode active.
REQ-014 SHALL have ports: win  out  1  no pellets remain.
REQ-015 SHALL have ports: pellet_count  out  9  pellets remaining.
REQ-016 SHALL have ports: busy  out  1  block is not IDLE.
REQ-017 SHALL have ports: overrun  out  1  sticky; a frame_tick arrived while busy.

Function
REQ-018 Tile info codes SHALL be: 00 open, 01 wall, 10 pellet, 11 power pellet.
REQ-019 Storage SHALL consist of:
- a constant wall map;
- a constant power-position map (4 tiles);
- a MAZE_W*MAZE_H pellet-present bit RAM with 1-cycle read latency.
- Tile index = y*MAZE_W + x.
REQ-020 A tile with its pellet bit clear SHALL report 00 unless it is a wall; a tile with its pellet bit set SHALL report 11 at a power position and 10 otherwise.
REQ-021 The FSM states SHALL be INIT, IDLE, SNAP, READ, EAT, COMMIT.
REQ-022 In INIT:
- the FSM SHALL walk every tile index, writing the initial pellet map;
- on completion, pellet_count SHALL load PELLET_TOTAL and the FSM SHALL go to IDLE.
REQ-023 In IDLE:
- frame_tick SHALL move the FSM to SNAP;
- level_restart SHALL move the FSM to INIT;
- level_restart has priority over frame_tick.
REQ-024 SNAP SHALL latch all five query buses and pause in one cycle; later changes on those inputs SHALL NOT affect the current frame.
REQ-025 READ SHALL issue 20 neighbor reads (characters in order pacman, blinky, pinky, inky, clyde; each up, left, down, right), pipelined one per cycle, into staging registers.
REQ-026 Neighbor address rules SHALL be:
- x-1 at x=0 wraps to MAZE_W-1, and x+1 at MAZE_W-1 wraps to 0 (tunnel);
- y-1 at y=0, and y+1 at y=MAZE_H-1, report 01;
- any center with x>=MAZE_W or y>=MAZE_H reports 01 for all four neighbors, with no RAM access.
REQ-027 EAT SHALL read the Pac-Man center tile; if its pellet bit is set and the latched pause is 0, it SHALL:
- clear the bit;
- decrement pellet_count;
- set the eat flag;
- set the power flag if the tile is a power position.
REQ-028 COMMIT SHALL update all five tile_info outputs, pacman_pellet and power state together in one cycle, then return to IDLE.
- Outputs SHALL hold until the next COMMIT.
REQ-029 Frame latency SHALL be at most 30 clk cycles from frame_tick to COMMIT.
REQ-030 pacman_pellet SHALL be a level equal to the eat flag at the last COMMIT; this gives one frame of assertion per pellet.
REQ-031 Power timer:
- an eaten power pellet SHALL reload the timer to POWER_FRAMES at COMMIT, including while the timer is already running;
- otherwise the timer SHALL decrement by 1 at each COMMIT with latched pause=0 while it is nonzero;
- power_pellet SHALL equal (timer != 0).
REQ-032 win SHALL equal (pellet_count == 0); pellet_count SHALL saturate at 0.
REQ-033 A frame_tick while busy SHALL be ignored and SHALL set overrun; overrun SHALL clear only on rst.
REQ-034 A level_restart while busy SHALL be held pending and taken on return to IDLE; the timer SHALL clear and pacman_pellet SHALL go to 0 on entering INIT.
REQ-035 busy SHALL be 1 in every state except IDLE.

Reset
REQ-036 rst SHALL force INIT and restart the pellet refill from index 0, including when asserted mid-frame or mid-INIT.
REQ-037 rst SHALL set the following outputs: all tile_info = 0, pacman_pellet = 0, power_pellet = 0, timer = 0, overrun = 0, pellet_count = 0.
REQ-038 rst SHALL assert win = 1 during INIT; win SHALL deassert once pellet_count = PELLET_TOTAL.

Verification
REQ-039 Reset then wait for busy=0 -> pellet_count=244, win=0; query a known corridor tile -> neighbor info matches the wall map exactly.
REQ-040 Pac-Man center on a normal pellet, frame_tick -> pacman_pellet=1 and pellet_count=243 at COMMIT, within 30 cycles; same tile on the next frame -> pacman_pellet=0, count unchanged, center reports 00.
REQ-041 Pac-Man center on a power pellet -> power_pellet=1, then stays high for exactly 360 unpaused frames and deasserts on the 360th COMMIT; a second power pellet at frame 100 -> the timer reloads to 360.
REQ-042 pause=1 at frame_tick on a pellet tile -> no eat and timer held; tunnel center x=0 -> left neighbor is read from x=27; center y=0 -> up neighbor = 01; x=40 -> info 8'h55.
REQ-043 Consume all 244 pellets -> win=1 and count stays 0; then level_restart -> busy until refill completes, then count=244 and win=0.
REQ-044 frame_tick mid-READ -> overrun=1 and the frame is ignored; rst mid-READ -> all outputs at reset values, then INIT restarts from index 0.

Source files
------------

// File: rtl/maze_state.sv
// maze_state -- tile server for a Pac-Man maze. Each frame it snapshots five characters,
// reads their neighbours from a pellet RAM, lets Pac-Man eat, and commits all results together.
`default_nettype none

module maze_state #(
  parameter int MAZE_W       = 28,
  parameter int MAZE_H       = 36,
  parameter int PELLET_TOTAL = 244,
  parameter int POWER_FRAMES = 360
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        pause,
  input  logic        level_restart,
  input  logic [11:0] pacman_tiles,
  input  logic [11:0] blinky_tiles,
  input  logic [11:0] pinky_tiles,
  input  logic [11:0] inky_tiles,
  input  logic [11:0] clyde_tiles,
  output logic [7:0]  pacman_tile_info,
  output logic [7:0]  blinky_tile_info,
  output logic [7:0]  pinky_tile_info,
  output logic [7:0]  inky_tile_info,
  output logic [7:0]  clyde_tile_info,
  output logic        pacman_pellet,
  output logic        power_pellet,
  output logic        win,
  output logic [8:0]  pellet_count,
  output logic        busy,
  output logic        overrun
);
  localparam int N  = MAZE_W * MAZE_H;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam int TW = $clog2(POWER_FRAMES + 1);
  localparam logic [5:0]    W6       = 6'(MAZE_W);
  localparam logic [5:0]    H6       = 6'(MAZE_H);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  // Border walls with a tunnel on the middle row, plus a grid of single-tile pillars.
  function automatic logic [N-1:0] build_walls();
    logic [N-1:0] m;
    m = '0;
    for (int y = 0; y < MAZE_H; y++)
      for (int x = 0; x < MAZE_W; x++)
        m[IW'(y * MAZE_W + x)] = (y == 0) || (y == MAZE_H - 1) ||
                                 ((x == 0 || x == MAZE_W - 1) && y != MAZE_H / 2) ||
                                 (x % 4 == 2 && y % 4 == 2);
    return m;
  endfunction

  function automatic logic [N-1:0] build_power();
    logic [N-1:0] m;
    m = '0;
    m[IW'(3 * MAZE_W + 1)]          = 1'b1;
    m[IW'(3 * MAZE_W + MAZE_W - 2)] = 1'b1;
    m[IW'(9 * MAZE_W + 1)]          = 1'b1;
    m[IW'(9 * MAZE_W + MAZE_W - 2)] = 1'b1;
    return m;
  endfunction

  localparam logic [N-1:0] WALL_MAP  = build_walls();
  localparam logic [N-1:0] POWER_MAP = build_power();

  typedef enum logic [2:0] {INIT, IDLE, SNAP, READ, EAT, COMMIT} state_t;
  state_t state, state_nx;

  logic          pellet_ram [N];
  logic          rdata;
  logic          ram_we, ram_wdata, ram_re;
  logic [IW-1:0] ram_waddr;

  logic [IW-1:0] init_idx;
  logic [CW-1:0] placed;
  logic [11:0]   ctr [5];
  logic          pause_l;
  logic [4:0]    rd_idx;
  logic          pd_valid, pd_forced;
  logic [4:0]    pd_slot;
  logic [IW-1:0] pd_idx;
  logic [1:0]    stage [20];
  logic          eat_flag, pow_flag, eat_now;
  logic [TW-1:0] timer;
  logic          restart_pend;

  logic [11:0]   q_ctr;
  logic [5:0]    qx, qy, nx, ny;
  logic          q_forced;
  logic [IW-1:0] q_idx;
  logic [1:0]    code;

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      INIT:    if (init_idx == LAST_IDX) state_nx = IDLE;
      IDLE:    if (level_restart || restart_pend) state_nx = INIT;
               else if (frame_tick)               state_nx = SNAP;
      SNAP:    state_nx = READ;
      READ:    if (rd_idx == 5'd20) state_nx = EAT;
      EAT:     state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = INIT;
    endcase
  end

  // Read slot k: character k/4, direction k%4 (up, left, down, right); slot 20 is Pac-Man's own tile.
  always_comb begin
    case (rd_idx[4:2])
      3'd1:    q_ctr = ctr[1];
      3'd2:    q_ctr = ctr[2];
      3'd3:    q_ctr = ctr[3];
      3'd4:    q_ctr = ctr[4];
      default: q_ctr = ctr[0];
    endcase
    qx       = q_ctr[11:6];
    qy       = q_ctr[5:0];
    nx       = qx;
    ny       = qy;
    q_forced = (qx >= W6) || (qy >= H6);
    if (rd_idx != 5'd20) begin
      case (rd_idx[1:0])
        2'd0:    if (qy == 6'd0) q_forced = 1'b1; else ny = qy - 6'd1;
        2'd1:    nx = (qx == 6'd0) ? W6 - 6'd1 : qx - 6'd1;
        2'd2:    if (qy == H6 - 6'd1) q_forced = 1'b1; else ny = qy + 6'd1;
        default: nx = (qx == W6 - 6'd1) ? 6'd0 : qx + 6'd1;
      endcase
    end
    q_idx = IW'(12'(ny) * 12'(W6) + 12'(nx));
  end

  always_comb begin
    eat_now   = (state == EAT) && !pd_forced && rdata && !pause_l;
    ram_re    = (state == READ) && !q_forced;
    ram_we    = 1'b0;
    ram_waddr = init_idx;
    ram_wdata = 1'b0;
    if (state == INIT) begin
      ram_we    = 1'b1;
      ram_wdata = !WALL_MAP[init_idx] && (placed < CW'(PELLET_TOTAL));
    end else if (eat_now) begin
      ram_we    = 1'b1;
      ram_waddr = pd_idx;
    end
    if (pd_forced || WALL_MAP[pd_idx]) code = 2'b01;
    else if (rdata)                    code = POWER_MAP[pd_idx] ? 2'b11 : 2'b10;
    else                               code = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (ram_we) pellet_ram[ram_waddr] <= ram_wdata;
    if (ram_re) rdata <= pellet_ram[q_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_idx         <= '0;
      placed           <= '0;
      for (int i = 0; i < 5; i++) ctr[i] <= '0;
      for (int i = 0; i < 20; i++) stage[i] <= 2'b00;
      pause_l          <= 1'b0;
      rd_idx           <= '0;
      pd_valid         <= 1'b0;
      pd_forced        <= 1'b0;
      pd_slot          <= '0;
      pd_idx           <= '0;
      eat_flag         <= 1'b0;
      pow_flag         <= 1'b0;
      timer            <= '0;
      restart_pend     <= 1'b0;
      overrun          <= 1'b0;
      pellet_count     <= '0;
      pacman_pellet    <= 1'b0;
      pacman_tile_info <= '0;
      blinky_tile_info <= '0;
      pinky_tile_info  <= '0;
      inky_tile_info   <= '0;
      clyde_tile_info  <= '0;
    end else begin
      if (frame_tick && state != IDLE) overrun <= 1'b1;
      if (state == IDLE && state_nx == INIT) begin
        restart_pend  <= 1'b0;
        timer         <= '0;
        pacman_pellet <= 1'b0;
        init_idx      <= '0;
        placed        <= '0;
      end else if (level_restart && state != IDLE) begin
        restart_pend <= 1'b1;
      end
      case (state)
        INIT: begin
          init_idx <= init_idx + IW'(1);
          if (ram_wdata) placed <= placed + CW'(1);
          if (init_idx == LAST_IDX) pellet_count <= 9'(PELLET_TOTAL);
        end
        SNAP: begin
          ctr[0]   <= pacman_tiles;
          ctr[1]   <= blinky_tiles;
          ctr[2]   <= pinky_tiles;
          ctr[3]   <= inky_tiles;
          ctr[4]   <= clyde_tiles;
          pause_l  <= pause;
          rd_idx   <= '0;
          eat_flag <= 1'b0;
          pow_flag <= 1'b0;
        end
        READ: rd_idx <= rd_idx + 5'd1;
        EAT: if (eat_now) begin
          eat_flag <= 1'b1;
          pow_flag <= POWER_MAP[pd_idx];
          if (pellet_count != 9'd0) pellet_count <= pellet_count - 9'd1;
        end
        COMMIT: begin
          pacman_tile_info <= {stage[0],  stage[1],  stage[2],  stage[3]};
          blinky_tile_info <= {stage[4],  stage[5],  stage[6],  stage[7]};
          pinky_tile_info  <= {stage[8],  stage[9],  stage[10], stage[11]};
          inky_tile_info   <= {stage[12], stage[13], stage[14], stage[15]};
          clyde_tile_info  <= {stage[16], stage[17], stage[18], stage[19]};
          pacman_pellet    <= eat_flag;
          if (pow_flag)                         timer <= TW'(POWER_FRAMES);
          else if (!pause_l && timer != '0)     timer <= timer - TW'(1);
        end
        default: ;
      endcase
      // Read results trail their address by one cycle.
      pd_valid  <= (state == READ);
      pd_slot   <= rd_idx;
      pd_forced <= q_forced;
      pd_idx    <= q_idx;
      if (pd_valid && pd_slot != 5'd20) stage[pd_slot] <= code;
    end
  end

  assign busy         = (state != IDLE);
  assign win          = (pellet_count == 9'd0);
  assign power_pellet = (timer != '0);

endmodule

`default_nettype wire
